ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-Lite memory slave that terminates one slave port of the multi-master interconnect and answers its per-slave address/data-phase stream. It decodes the local offset, inserts a programmable number of wait states, and commits writes under byte strobes. It returns read data and produces the two-cycle AHB ERROR response for illegal transfers. One instance sits behind each `ahbSlaveInterface[s]`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, bus address width.
- `DATA_WIDTH`, 32, bus data width; 32 or 64 only.
- `MEM_ADDR_BITS`, 10, log2 of the slave window in bytes; equals `SLAVE_MEMORY_SIZE`.
- `WAIT_STATES`, 0, wait cycles (`hreadyout`=0, OKAY) before each OKAY completion; range 0..15.

Ports:
- `hclk`  in  1  clock; everything on the rising edge.
- `hresetn`  in  1  asynchronous, active-low reset.
- `hselx`  in  1  slave select from interconnect.
- `haddr`  in  ADDR_WIDTH  address; only `haddr[MEM_ADDR_BITS-1:0]` is used.
- `htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hwrite`  in  1  1 = write.
- `hsize`  in  3  transfer size, log2 bytes.
- `hburst`, `hprot`, `hmastlock`  in  3/4/1  accepted and ignored.
- `hwdata`  in  DATA_WIDTH  write data, valid in the data phase.
- `hwstrb`  in  DATA_WIDTH/8  write byte strobes, data phase.
- `hready`  in  1  bus-level ready; an address phase is taken only when it is 1.
- `hreadyout`  out  1  slave ready.
- `hresp`  out  2  00 OKAY, 01 ERROR.
- `hrdata`  out  DATA_WIDTH  read data.

## Operation
- Accept condition: `hselx && hready && htrans[1]`. On accept, the block registers the word index, byte offset, `hsize` and `hwrite`.
- IDLE/BUSY transfers, and unselected cycles, get a zero-wait OKAY. They cause no state change and no memory access.
- Error checks at accept time:
  - `hsize` > log2(DATA_WIDTH/8) is an ERROR.
  - An address not aligned to `hsize` is an ERROR.
  - An errored write never touches memory.
- Write lane mask: `hwstrb` AND the lanes implied by `hsize` and the byte offset. All-zero strobes give an OKAY completion with no change.
- Write commit: the masked bytes are written at the rising edge that ends the final data-phase cycle (`hreadyout`=1).
- Read data: `hrdata` = word at the registered index, driven combinationally during the final data-phase cycle of a read. `hrdata` is 0 in every other cycle.
- Memory contents are not reset. Bench preloads memory or writes it before reading.
- State machine:
  - IDLE: no data phase pending. On accept, go to ERR1 if the transfer is illegal. Otherwise go to WAIT if `WAIT_STATES`>0, else to DATA.
  - WAIT: `hreadyout`=0, `hresp`=OKAY. The counter loads `WAIT_STATES` and decrements; go to DATA when the counter reaches 1.
  - DATA: `hreadyout`=1, OKAY, transfer completes. A new accept in this cycle follows the IDLE transition rules; otherwise go to IDLE.
  - ERR1: `hreadyout`=0, `hresp`=ERROR; always go to ERR2.
  - ERR2: `hreadyout`=1, `hresp`=ERROR. A new accept follows the IDLE rules; otherwise go to IDLE.

## Timing
- Reset values: `hreadyout`=1, `hresp`=00, `hrdata`=0, state IDLE, wait counter 0.
- Reset asserted mid-transfer aborts it immediately. A pending write is not committed.
- OKAY latency after the address phase is `WAIT_STATES`+1 cycles. ERROR latency is always 2 cycles, independent of `WAIT_STATES`.
- Back-to-back pipelining: the next address phase overlaps the final cycle (DATA/ERR2), giving zero bubble cycles.
- Read-after-write to the same word in the next data phase returns the new data; no forwarding path is needed.
- No accept is possible in WAIT or ERR1, because `hready` is 0 in those cycles.

## Structure
- Shared in `AhbGlobalPackage`: `ADDR_WIDTH`, `DATA_WIDTH`, `SLAVE_MEMORY_SIZE`, an htrans enum (IDLE/BUSY/NONSEQ/SEQ), an hresp enum (OKAY/ERROR), and a size-to-lane-mask function.
- Local to this block: the state enum {IDLE, WAIT, DATA, ERR1, ERR2}.
- Sub-module `ahb_sram_mem_array` holds the storage:
  - 2^(MEM_ADDR_BITS)/(DATA_WIDTH/8) words.
  - One write port with per-byte enables.
  - One asynchronous read port.

## Test plan
- Reset, then hold idle → `hreadyout`=1, `hresp`=00, `hrdata`=0.
- `WAIT_STATES`=0: write 0xDEADBEEF to 0x004 with strobe 0xF, then read 0x004 back-to-back → read completes one cycle after its address phase with 0xDEADBEEF, no bubbles.
- `WAIT_STATES`=3: read 0x010 → `hreadyout` low for 3 cycles, then high with data and OKAY.
- Word 0x020 = 0x11223344; halfword write 0xAAAA to 0x022 → word reads 0xAAAA3344. Strobe 0x0 write → word unchanged.
- Word write to 0x001 and `hsize`=3 (with `DATA_WIDTH`=32) → ERR1 (`hreadyout`=0, `hresp`=01) then ERR2 (`hreadyout`=1, `hresp`=01); memory unchanged.
- `hresetn` asserted during the second wait cycle of a write → outputs return to reset values immediately; a later read of that word shows the old data.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg
//   Shared AHB-Lite definitions for the SRAM slave: default bus geometry,
//   the htrans and hresp encodings, and the helper that turns a transfer size
//   plus byte offset into the set of byte lanes that transfer occupies.
package ahb_sram_slave_pkg;

    localparam int unsigned AHB_ADDR_WIDTH    = 32;
    localparam int unsigned AHB_DATA_WIDTH    = 32;
    localparam int unsigned SLAVE_MEMORY_SIZE = 10;

    typedef enum logic [1:0] {
        HtransIdle   = 2'b00,
        HtransBusy   = 2'b01,
        HtransNonseq = 2'b10,
        HtransSeq    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HrespOkay  = 2'b00,
        HrespError = 2'b01
    } hresp_e;

    // Lanes [offset, offset + 2**size) are set; callers keep the low
    // DATA_WIDTH/8 bits.
    function automatic logic [7:0] size_lane_mask(input logic [2:0] size,
                                                  input logic [2:0] offset);
        logic [7:0] mask;
        int         lo;
        int         hi;
        lo = int'(offset);
        hi = lo + (1 << size);
        for (int i = 0; i < 8; i++) begin
            mask[i] = (i >= lo) && (i < hi);
        end
        return mask;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if
//   One AHB-Lite slave port as seen behind the interconnect.
//   master modport: drives select, address phase, write data/strobes, hready.
//   slave modport : drives hreadyout, hresp and hrdata.
interface ahb_sram_slave_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);

    logic                    hselx;
    logic [ADDR_WIDTH-1:0]   haddr;
    logic [1:0]              htrans;
    logic                    hwrite;
    logic [2:0]              hsize;
    logic [2:0]              hburst;
    logic [3:0]              hprot;
    logic                    hmastlock;
    logic [DATA_WIDTH-1:0]   hwdata;
    logic [DATA_WIDTH/8-1:0] hwstrb;
    logic                    hready;
    logic                    hreadyout;
    logic [1:0]              hresp;
    logic [DATA_WIDTH-1:0]   hrdata;

    modport master (
        output hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        output hwdata, hwstrb, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hselx, haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        input  hwdata, hwstrb, hready,
        output hreadyout, hresp, hrdata
    );

endinterface

// File: rtl/ahb_sram_mem_array.sv
// ahb_sram_mem_array
//   Word-organised storage for the SRAM slave. Contents are not reset.
//   clk_i   : write clock
//   we_i    : write enable, be_i per-byte enables, waddr_i/wdata_i write port
//   raddr_i : asynchronous read address, rdata_o read data
module ahb_sram_mem_array #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned AddrBits  = $clog2(DEPTH),
    localparam int unsigned StrbWidth = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [StrbWidth-1:0]  be_i,
    input  logic [AddrBits-1:0]   waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AddrBits-1:0]   raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < int'(StrbWidth); b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite memory slave. Takes address phases from the interconnect, adds
//   WAIT_STATES wait cycles before each OKAY completion, commits writes under
//   byte strobes masked by the transfer size, returns read data in the final
//   data-phase cycle, and gives the two-cycle ERROR response for oversize or
//   misaligned transfers.
//   hclk    : clock, rising edge
//   hresetn : asynchronous active-low reset
//   bus     : slave side of the AHB-Lite port
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = AHB_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = AHB_DATA_WIDTH,
    parameter int unsigned MEM_ADDR_BITS = SLAVE_MEMORY_SIZE,
    parameter int unsigned WAIT_STATES   = 0
) (
    input logic             hclk,
    input logic             hresetn,
    ahb_sram_slave_if.slave bus
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned ByteBits  = $clog2(StrbWidth);
    localparam int unsigned WordBits  = MEM_ADDR_BITS - ByteBits;
    localparam int unsigned Depth     = 1 << WordBits;
    localparam logic [3:0]  WaitLoad  = 4'(WAIT_STATES);
    localparam logic [2:0]  MaxSize   = 3'(ByteBits);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [WordBits-1:0]   word_idx_q, word_idx_d;
    logic [ByteBits-1:0]   byte_off_q, byte_off_d;
    logic [2:0]            hsize_q, hsize_d;
    logic                  hwrite_q, hwrite_d;

    logic                  accept;
    logic                  misaligned;
    logic                  illegal;
    logic [ByteBits-1:0]   addr_off;
    logic [WordBits-1:0]   addr_word;
    logic [7:0]            lane_mask_full;
    logic [StrbWidth-1:0]  wr_be;
    logic                  take_addr;
    logic                  data_done;
    logic                  hreadyout_c;
    hresp_e                hresp_c;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_bits;

    // Address-phase decode
    assign accept    = bus.hselx & bus.hready & bus.htrans[1];
    assign addr_off  = bus.haddr[ByteBits-1:0];
    assign addr_word = bus.haddr[MEM_ADDR_BITS-1:ByteBits];

    // Any offset bit below the transfer size being set means misaligned.
    always_comb begin
        misaligned = 1'b0;
        for (int i = 0; i < int'(ByteBits); i++) begin
            if ((i < int'(bus.hsize)) && addr_off[i]) begin
                misaligned = 1'b1;
            end
        end
    end

    assign illegal = (bus.hsize > MaxSize) | misaligned;

    // Data-phase write lanes: strobes restricted to the lanes of the transfer.
    assign lane_mask_full = size_lane_mask(hsize_q, 3'(byte_off_q));
    assign wr_be          = bus.hwstrb & lane_mask_full[StrbWidth-1:0];

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        word_idx_d  = word_idx_q;
        byte_off_d  = byte_off_q;
        hsize_d     = hsize_q;
        hwrite_d    = hwrite_q;
        take_addr   = 1'b0;
        data_done   = 1'b0;
        hreadyout_c = 1'b1;
        hresp_c     = HrespOkay;

        case (state_q)
            StIdle: begin
                take_addr = 1'b1;
            end
            StWait: begin
                hreadyout_c = 1'b0;
                if (wait_cnt_q == 4'd1) begin
                    state_d    = StData;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StData: begin
                data_done = 1'b1;
                take_addr = 1'b1;
            end
            StErr1: begin
                hreadyout_c = 1'b0;
                hresp_c     = HrespError;
                state_d     = StErr2;
            end
            StErr2: begin
                hresp_c   = HrespError;
                take_addr = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Final cycles (and idle) can overlap the next address phase.
        if (take_addr) begin
            if (accept) begin
                word_idx_d = addr_word;
                byte_off_d = addr_off;
                hsize_d    = bus.hsize;
                hwrite_d   = bus.hwrite;
                if (illegal) begin
                    state_d = StErr1;
                end else if (WaitLoad != 4'd0) begin
                    state_d    = StWait;
                    wait_cnt_d = WaitLoad;
                end else begin
                    state_d = StData;
                end
            end else begin
                state_d = StIdle;
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            word_idx_q <= '0;
            byte_off_q <= '0;
            hsize_q    <= '0;
            hwrite_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            word_idx_q <= word_idx_d;
            byte_off_q <= byte_off_d;
            hsize_q    <= hsize_d;
            hwrite_q   <= hwrite_d;
        end
    end

    assign mem_we        = data_done & hwrite_q;
    assign bus.hreadyout = hreadyout_c;
    assign bus.hresp     = hresp_c;
    assign bus.hrdata    = (data_done & ~hwrite_q) ? mem_rdata : '0;

    ahb_sram_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (Depth)
    ) u_mem (
        .clk_i   (hclk),
        .we_i    (mem_we),
        .be_i    (wr_be),
        .waddr_i (word_idx_q),
        .wdata_i (bus.hwdata),
        .raddr_i (word_idx_q),
        .rdata_o (mem_rdata)
    );

    // Bus fields this slave does not act on.
    assign unused_bits = ^{bus.haddr[ADDR_WIDTH-1:MEM_ADDR_BITS], bus.htrans[0],
                           bus.hburst, bus.hprot, bus.hmastlock};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave
//   Two slaves (0 and 3 wait states) driven by a pipelined AHB-Lite master
//   and checked against a byte-array memory model and the response rules.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic hclk    = 1'b0;
    logic hresetn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus3 ();

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_BITS(10), .WAIT_STATES(0)
    ) u_dut0 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus0)
    );

    ahb_sram_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_ADDR_BITS(10), .WAIT_STATES(3)
    ) u_dut3 (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus3)
    );

    // Master-side drive, one entry per slave
    logic        sel   [2];
    logic [1:0]  trans [2];
    logic [31:0] addr  [2];
    logic        wr    [2];
    logic [2:0]  size  [2];
    logic [31:0] wdat  [2];
    logic [3:0]  strb  [2];
    logic        rdy_o  [2];
    logic [1:0]  resp_o [2];
    logic [31:0] rd_o   [2];

    assign bus0.hselx = sel[0];   assign bus3.hselx = sel[1];
    assign bus0.htrans = trans[0]; assign bus3.htrans = trans[1];
    assign bus0.haddr = addr[0];  assign bus3.haddr = addr[1];
    assign bus0.hwrite = wr[0];   assign bus3.hwrite = wr[1];
    assign bus0.hsize = size[0];  assign bus3.hsize = size[1];
    assign bus0.hwdata = wdat[0]; assign bus3.hwdata = wdat[1];
    assign bus0.hwstrb = strb[0]; assign bus3.hwstrb = strb[1];
    assign bus0.hburst = 3'b001;  assign bus3.hburst = 3'b001;
    assign bus0.hprot = 4'b0011;  assign bus3.hprot = 4'b0011;
    assign bus0.hmastlock = 1'b0; assign bus3.hmastlock = 1'b0;
    assign bus0.hready = bus0.hreadyout;
    assign bus3.hready = bus3.hreadyout;
    assign rdy_o[0] = bus0.hreadyout; assign rdy_o[1] = bus3.hreadyout;
    assign resp_o[0] = bus0.hresp;    assign resp_o[1] = bus3.hresp;
    assign rd_o[0] = bus0.hrdata;     assign rd_o[1] = bus3.hrdata;

    typedef struct {
        bit          act;
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } xfer_t;

    xfer_t       q[$];
    logic [7:0]  mm [2][1024];
    logic [31:0] last_rd;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_illegal(input xfer_t x);
        return (x.size > 3'd2) || ((x.addr & ((32'd1 << x.size) - 32'd1)) != 32'd0);
    endfunction

    function automatic logic [31:0] model_word(input int b, input logic [31:0] a);
        int base;
        base = int'(a[9:2]) * 4;
        return {mm[b][base+3], mm[b][base+2], mm[b][base+1], mm[b][base]};
    endfunction

    task automatic model_write(input int b, input xfer_t x);
        int base;
        int off;
        base = int'(x.addr[9:2]) * 4;
        off  = int'(x.addr[1:0]);
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + (1 << x.size) && x.strb[i]) begin
                mm[b][base+i] = x.wdata[8*i +: 8];
            end
        end
    endtask

    task automatic push(input bit w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] d, input logic [3:0] s);
        xfer_t x;
        x.act = 1'b1; x.sel = 1'b1; x.trans = 2'b10; x.wr = w;
        x.addr = a; x.size = sz; x.wdata = d; x.strb = s;
        q.push_back(x);
    endtask

    // Pipelined master: address of the next transfer overlaps the data phase
    // of the current one; hready is the slave's own hreadyout.
    task automatic run_queue(input int b, input int ws);
        xfer_t       ap;
        xfer_t       dp;
        bit          ap_v = 1'b0;
        bit          dp_v = 1'b0;
        bit          err;
        logic        hr;
        int          low = 0;
        int          guard = 0;
        logic [31:0] exp_rd;
        while ((q.size() != 0 || ap_v || dp_v) && guard < 1000) begin
            guard++;
            if (!ap_v && q.size() != 0) begin
                ap = q.pop_front();
                ap_v = 1'b1;
            end
            sel[b]   = ap_v ? ap.sel : 1'b0;
            trans[b] = ap_v ? ap.trans : 2'b00;
            addr[b]  = ap_v ? ap.addr : 32'h0;
            wr[b]    = ap_v ? ap.wr : 1'b0;
            size[b]  = ap_v ? ap.size : 3'd2;
            wdat[b]  = dp_v ? dp.wdata : $urandom();
            strb[b]  = dp_v ? dp.strb : 4'hF;
            @(negedge hclk);
            if (dp_v) begin
                err = is_illegal(dp);
                chk("resp", 32'(resp_o[b]), err ? 32'd1 : 32'd0);
                if (rdy_o[b] !== 1'b1) begin
                    low++;
                    chk("rdata_wait", rd_o[b], 32'h0);
                end else begin
                    chk("wait_cycles", low, err ? 32'd1 : 32'(ws));
                    exp_rd = (!err && !dp.wr) ? model_word(b, dp.addr) : 32'h0;
                    chk("rdata", rd_o[b], exp_rd);
                    if (!err && !dp.wr) last_rd = rd_o[b];
                    if (!err && dp.wr) model_write(b, dp);
                    low = 0;
                end
            end else begin
                chk("idle_rdy", 32'(rdy_o[b]), 32'd1);
                chk("idle_resp", 32'(resp_o[b]), 32'd0);
                chk("idle_rdata", rd_o[b], 32'h0);
            end
            hr = rdy_o[b];
            @(posedge hclk); #1;
            if (hr === 1'b1) begin
                dp_v = ap_v && ap.act;
                dp   = ap;
                ap_v = 1'b0;
            end
        end
        chk("queue_drained", 32'(guard < 1000), 32'd1);
        sel[b] = 1'b0; trans[b] = 2'b00;
    endtask

    task automatic preload(input int b);
        for (int w = 0; w < 16; w++) push(1'b1, 32'(w * 4), 3'd2, $urandom(), 4'hF);
        push(1'b1, 32'h3FC, 3'd2, $urandom(), 4'hF);
    endtask

    task automatic random_burst(input int b, input int n);
        xfer_t       x;
        logic [31:0] r;
        logic [7:0]  w;
        for (int i = 0; i < n; i++) begin
            r = $urandom();
            w = ($urandom_range(0, 16) == 16) ? 8'hFF : 8'($urandom_range(0, 15));
            x.act   = 1'b1;
            x.sel   = 1'b1;
            x.trans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
            x.wr    = 1'($urandom_range(0, 1));
            x.addr  = {r[31:10], w, 2'($urandom_range(0, 3))};
            x.size  = 3'($urandom_range(0, 3));
            x.wdata = $urandom();
            x.strb  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 4) == 0) begin
                // Idle/busy or unselected: no data phase
                x.act   = 1'b0;
                x.sel   = 1'($urandom_range(0, 1));
                x.trans = x.sel ? 2'($urandom_range(0, 1)) : 2'b10;
            end
            q.push_back(x);
        end
    endtask

    logic [31:0] old_word;

    initial begin
        for (int b = 0; b < 2; b++) begin
            sel[b] = 1'b0; trans[b] = 2'b00; addr[b] = 32'h0; wr[b] = 1'b0;
            size[b] = 3'd2; wdat[b] = 32'h0; strb[b] = 4'h0;
        end
        repeat (3) @(posedge hclk);
        #1;
        for (int b = 0; b < 2; b++) begin
            chk("rst_rdy", 32'(rdy_o[b]), 32'd1);
            chk("rst_resp", 32'(resp_o[b]), 32'd0);
            chk("rst_rdata", rd_o[b], 32'h0);
        end
        hresetn = 1'b1;
        repeat (2) @(posedge hclk);
        #1;

        preload(0); run_queue(0, 0);
        preload(1); run_queue(1, 3);

        // Zero-wait write then back-to-back read of the same word
        push(1'b1, 32'h004, 3'd2, 32'hDEADBEEF, 4'hF);
        push(1'b0, 32'h004, 3'd2, 32'h0, 4'h0);
        run_queue(0, 0);
        chk("rd_deadbeef", last_rd, 32'hDEADBEEF);

        // Three wait states on a read
        push(1'b1, 32'h010, 3'd2, 32'h0BADC0DE, 4'hF);
        push(1'b0, 32'h010, 3'd2, 32'h0, 4'h0);
        run_queue(1, 3);
        chk("rd_ws3", last_rd, 32'h0BADC0DE);

        // Halfword write under full strobes, then all-zero strobes
        push(1'b1, 32'h020, 3'd2, 32'h11223344, 4'hF);
        push(1'b1, 32'h022, 3'd1, 32'hAAAA5555, 4'hF);
        push(1'b0, 32'h020, 3'd2, 32'h0, 4'h0);
        run_queue(0, 0);
        chk("rd_halfword", last_rd, 32'hAAAA3344);
        push(1'b1, 32'h020, 3'd2, 32'hFFFFFFFF, 4'h0);
        push(1'b0, 32'h020, 3'd2, 32'h0, 4'h0);
        run_queue(0, 0);
        chk("rd_zero_strb", last_rd, 32'hAAAA3344);

        // Misaligned and oversize writes leave memory untouched
        push(1'b1, 32'h024, 3'd2, 32'hCAFEF00D, 4'hF);
        push(1'b1, 32'h025, 3'd2, 32'h12345678, 4'hF);
        push(1'b1, 32'h024, 3'd3, 32'h87654321, 4'hF);
        push(1'b0, 32'h024, 3'd2, 32'h0, 4'h0);
        run_queue(0, 0);
        chk("rd_after_err", last_rd, 32'hCAFEF00D);
        push(1'b1, 32'h001, 3'd2, 32'h0, 4'hF);
        run_queue(1, 3);

        random_burst(0, 60); run_queue(0, 0);
        random_burst(1, 40); run_queue(1, 3);

        // Reset in the second wait cycle of a write aborts it
        old_word = model_word(1, 32'h010);
        sel[1] = 1'b1; trans[1] = 2'b10; addr[1] = 32'h010; wr[1] = 1'b1; size[1] = 3'd2;
        @(posedge hclk); #1;
        sel[1] = 1'b0; trans[1] = 2'b00; wdat[1] = ~old_word; strb[1] = 4'hF;
        chk("abort_wait1", 32'(rdy_o[1]), 32'd0);
        @(posedge hclk); #1;
        chk("abort_wait2", 32'(rdy_o[1]), 32'd0);
        #2 hresetn = 1'b0;
        #1;
        chk("abort_rdy", 32'(rdy_o[1]), 32'd1);
        chk("abort_resp", 32'(resp_o[1]), 32'd0);
        chk("abort_rdata", rd_o[1], 32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(posedge hclk); #1;
        push(1'b0, 32'h010, 3'd2, 32'h0, 4'h0);
        run_queue(1, 3);
        chk("abort_old_data", last_rd, old_word);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
